mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine. Consumes the ALU->MEM pipeline register outputs
//  (address/result, write-back info), issues word-wide req/ack transactions to data RAM,
//  aligns/extends load data and presents results to the MEM/WB register.
//  Stalls the upstream pipeline while a RAM transaction is outstanding.
// PARAMETERS
//  DATA_W      32  data and address width (`DataSize)
//  REG_ADDR_W  5   register-file address width (`RegAddrSize)
// PORTS
//  clk               in   1           rising-edge clock
//  resetIn_n         in   1           async active-low reset
//  validIn           in   1           ALU->MEM entry valid this cycle
//  memOpIn           in   2           00 none, 01 load, 10 store, 11 reserved (treated as none)
//  funct3In          in   3           RV32I size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dataIn            in   DATA_W      ALU result; effective address when memOpIn != 00
//  storeDataIn       in   DATA_W      rs2 value for stores
//  writeEnableIn     in   1           write-back request from DEC_ALU
//  writeBackAddrIn   in   REG_ADDR_W  destination register
//  flushIn           in   1           kill entry presented this cycle
//  stallOut          out  1           hold ALU->MEM register (combinational)
//  memReq            out  1           RAM request
//  memWe             out  1           1 = write
//  memAddr           out  DATA_W      word address, bits [1:0] = 00
//  memWdata          out  DATA_W      store data, lane-replicated
//  memBe             out  4           byte enables
//  memAck            in   1           RAM completes request (rdata valid same cycle)
//  memRdata          in   DATA_W      read word
//  wbValidOut        out  1           MEM/WB entry valid
//  writeEnableOut    out  1           write-back enable to MEM_WB
//  writeBackAddrOut  out  REG_ADDR_W  destination to MEM_WB
//  dataOut           out  DATA_W      result to MEM_WB
//  misalignOut       out  1           1-cycle pulse: misaligned access dropped
// BEHAVIOUR
//  - Reset: FSM IDLE; all registered outputs 0 (memAddr/memWdata/dataOut=0, memBe=0).
//  - FSM IDLE/WAIT. IDLE, validIn & !flushIn:
//    . memOp none: registered pass-through next cycle; wbValidOut=1, dataOut=dataIn, 1-cycle latency.
//    . misaligned (H with addr[0]; W with addr[1:0]!=0): no request; next cycle
//      misalignOut=1, wbValidOut=1, writeEnableOut=0.
//    . aligned load/store: memReq/memWe/memAddr/memBe/memWdata registered, -> WAIT.
//  - stallOut = (IDLE & validIn & !flushIn & aligned mem op) | (WAIT & !memAck).
//  - WAIT: request fields held stable until memAck. On memAck: memReq<=0, -> IDLE,
//    wbValidOut=1 next cycle. Load: byte/half selected by addr[1:0], sign-extended
//    (B,H) or zero-extended (BU,HU). Store: writeEnableOut=0. Total latency = ack wait + 2.
//  - memBe: B -> 1<<addr[1:0]; H -> 0011/1100; W -> 1111. memWdata: B byte x4, H half x2.
//  - memAck in IDLE ignored. Ack on first WAIT cycle allowed (0-wait RAM).
//  - flushIn in WAIT: transaction completes (never abort RAM); result dropped
//    (wbValidOut=0). flushIn in IDLE: entry discarded, nothing issued.
//  - wbValidOut/misalignOut are single-cycle unless a new entry follows.
//  - Async reset mid-WAIT: memReq drops immediately; RAM must tolerate abandoned request.
// STRUCTURE
//  - Shared package/define.v: MEMOP_* codes, FUNCT3_LB..LHU, `DataSize, `RegAddrSize.
//  - Sub-module load_align (comb): {memRdata, addr[1:0], funct3} -> extended load value;
//    store lane/byte-enable generation stays inline.
// TESTING
//  1 ALU op: validIn=1, memOp=00, dataIn=0x1234, wbAddr=5 -> next cycle wbValid=1,
//    dataOut=0x1234, writeEnableOut=1, stallOut never high.
//  2 LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles -> memAddr=0x100, be=1000,
//    stallOut high 3 cycles, dataOut=0xFFFF_FF80.
//  3 SH addr 0x22, storeData 0xABCD -> memWe=1, be=1100, wdata=0xABCD_ABCD,
//    writeEnableOut=0.
//  4 LW addr 0x05 -> no memReq, misalignOut pulse, writeEnableOut=0.
//  5 flushIn asserted in WAIT, ack later -> no wbValidOut; next LW issues normally.
//  6 resetIn_n low during WAIT -> memReq=0 immediately; all outputs 0; FSM IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared memory-op codes, RV32I size codes and FSM states for the MEM stage.
package mem_access_unit_pkg;

    localparam int DATA_SIZE     = 32;
    localparam int REG_ADDR_SIZE = 5;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic       load;
        logic       we;
        logic [1:0] off;
        logic [2:0] funct3;
        logic       drop;
    } pend_t;

    // size is funct3[1:0]: 00 byte, 01 half, anything else word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size == 2'b01 && addr[0]) || (size[1] && addr != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_access_unit_load_align: selects the addressed byte/half of a read word and extends it.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = rdata[{off, 3'b000} +: 8];
        h     = off[1] ? rdata[31:16] : rdata[15:0];
        value = funct3[1:0] == 2'b00 ? {{24{b[7] & ~funct3[2]}}, b} :
                funct3[1:0] == 2'b01 ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with a req/ack data-RAM port.
// Holds the upstream pipeline while a RAM transaction is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_SIZE,
    parameter int REG_ADDR_W = REG_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  resetIn_n,
    input  logic                  validIn,
    input  logic [1:0]            memOpIn,
    input  logic [2:0]            funct3In,
    input  logic [DATA_W-1:0]     dataIn,
    input  logic [DATA_W-1:0]     storeDataIn,
    input  logic                  writeEnableIn,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    input  logic                  flushIn,
    output logic                  stallOut,
    output logic                  memReq,
    output logic                  memWe,
    output logic [DATA_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWdata,
    output logic [3:0]            memBe,
    input  logic                  memAck,
    input  logic [DATA_W-1:0]     memRdata,
    output logic                  wbValidOut,
    output logic                  writeEnableOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut,
    output logic [DATA_W-1:0]     dataOut,
    output logic                  misalignOut
);

    logic [0:0]            state;
    pend_t                 pend;
    logic [REG_ADDR_W-1:0] pend_wa;
    logic                  accept, is_mem, mis, issue, drop;
    logic [3:0]            be;
    logic [DATA_W-1:0]     wdata, ld_val;

    mem_access_unit_load_align u_align (
        .rdata  (memRdata),
        .off    (pend.off),
        .funct3 (pend.funct3),
        .value  (ld_val)
    );

    always_comb begin
        accept   = state == ST_IDLE && validIn && !flushIn;
        is_mem   = memOpIn == MEMOP_LOAD || memOpIn == MEMOP_STORE;
        mis      = is_mem && misaligned(funct3In[1:0], dataIn[1:0]);
        issue    = accept && is_mem && !mis;
        drop     = pend.drop || flushIn;
        stallOut = issue || (state == ST_WAIT && !memAck);
        be       = funct3In[1:0] == 2'b00 ? 4'b0001 << dataIn[1:0] :
                   funct3In[1:0] == 2'b01 ? (dataIn[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata    = funct3In[1:0] == 2'b00 ? {4{storeDataIn[7:0]}} :
                   funct3In[1:0] == 2'b01 ? {2{storeDataIn[15:0]}} : storeDataIn;
    end

    always_ff @(posedge clk or negedge resetIn_n) begin
        if (!resetIn_n) begin
            state            <= ST_IDLE;
            pend             <= '0;
            pend_wa          <= '0;
            memReq           <= 1'b0;
            memWe            <= 1'b0;
            memAddr          <= '0;
            memWdata         <= '0;
            memBe            <= 4'b0000;
            wbValidOut       <= 1'b0;
            writeEnableOut   <= 1'b0;
            writeBackAddrOut <= '0;
            dataOut          <= '0;
            misalignOut      <= 1'b0;
        end else begin
            wbValidOut     <= 1'b0;
            misalignOut    <= 1'b0;
            writeEnableOut <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept && !issue) begin
                    wbValidOut       <= 1'b1;
                    misalignOut      <= mis;
                    writeEnableOut   <= writeEnableIn && !mis;
                    writeBackAddrOut <= writeBackAddrIn;
                    dataOut          <= dataIn;
                end
                if (issue) begin
                    state    <= ST_WAIT;
                    memReq   <= 1'b1;
                    memWe    <= memOpIn == MEMOP_STORE;
                    memAddr  <= {dataIn[DATA_W-1:2], 2'b00};
                    memBe    <= be;
                    memWdata <= wdata;
                    pend     <= '{load: memOpIn == MEMOP_LOAD, we: writeEnableIn,
                                  off: dataIn[1:0], funct3: funct3In, drop: 1'b0};
                    pend_wa  <= writeBackAddrIn;
                end
            end else begin
                // a flushed transaction still runs to completion; only its result is dropped
                pend.drop <= drop;
                if (memAck) begin
                    state            <= ST_IDLE;
                    memReq           <= 1'b0;
                    memWe            <= 1'b0;
                    wbValidOut       <= !drop;
                    writeEnableOut   <= pend.load && pend.we && !drop;
                    writeBackAddrOut <= pend_wa;
                    dataOut          <= ld_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store/flush/reset sequence with a write-back scoreboard.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetIn_n;
    logic        validIn;
    logic [1:0]  memOpIn;
    logic [2:0]  funct3In;
    logic [31:0] dataIn, storeDataIn;
    logic        writeEnableIn;
    logic [4:0]  writeBackAddrIn;
    logic        flushIn;
    logic        stallOut, memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memBe;
    logic        memAck;
    logic [31:0] memRdata;
    logic        wbValidOut, writeEnableOut;
    logic [4:0]  writeBackAddrOut;
    logic [31:0] dataOut;
    logic        misalignOut;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  wa;
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        cd;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .resetIn_n        (resetIn_n),
        .validIn          (validIn),
        .memOpIn          (memOpIn),
        .funct3In         (funct3In),
        .dataIn           (dataIn),
        .storeDataIn      (storeDataIn),
        .writeEnableIn    (writeEnableIn),
        .writeBackAddrIn  (writeBackAddrIn),
        .flushIn          (flushIn),
        .stallOut         (stallOut),
        .memReq           (memReq),
        .memWe            (memWe),
        .memAddr          (memAddr),
        .memWdata         (memWdata),
        .memBe            (memBe),
        .memAck           (memAck),
        .memRdata         (memRdata),
        .wbValidOut       (wbValidOut),
        .writeEnableOut   (writeEnableOut),
        .writeBackAddrOut (writeBackAddrOut),
        .dataOut          (dataOut),
        .misalignOut      (misalignOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic we,
                         input logic [4:0] wa, input logic fl);
        validIn = v; memOpIn = op; funct3In = f3; dataIn = a; storeDataIn = sd;
        writeEnableIn = we; writeBackAddrIn = wa; flushIn = fl;
    endtask

    task automatic push(input logic [4:0] wa, input logic we, input logic [31:0] d,
                        input logic mis, input logic cd);
        exp_t e;
        e = '{wa: wa, we: we, data: d, mis: mis, cd: cd};
        q.push_back(e);
    endtask

    // entry that completes in one cycle: pass-through or misaligned drop
    task automatic do_single(input string tag, input logic [1:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [4:0] wa,
                             input logic exp_we, input logic exp_mis);
        step;
        drive(1'b1, op, f3, a, 32'h0, 1'b1, wa, 1'b0);
        push(wa, exp_we, a, exp_mis, !exp_mis);
        #1 chk({tag, "_stall"}, stallOut, 1'b0);
        step;
        validIn = 1'b0;
        chk({tag, "_noreq"}, memReq, 1'b0);
    endtask

    task automatic do_mem(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input logic [4:0] wa, input int nwait, input int flush_at,
                          input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] edata);
        int stalls;
        step;
        drive(1'b1, op, f3, a, sd, 1'b1, wa, 1'b0);
        #1 chk({tag, "_issue_stall"}, stallOut, 1'b1);
        if (flush_at < 0) push(wa, op == MEMOP_LOAD, edata, 1'b0, op == MEMOP_LOAD);
        stalls = 1;
        step;
        chk({tag, "_req"}, memReq, 1'b1);
        chk({tag, "_we"}, memWe, op == MEMOP_STORE);
        chk({tag, "_addr"}, memAddr, eaddr);
        chk({tag, "_be"}, {28'h0, memBe}, {28'h0, ebe});
        if (op == MEMOP_STORE) chk({tag, "_wdata"}, memWdata, ewd);
        for (int i = 0; i < nwait; i++) begin
            memAck = 1'b0;
            flushIn = (i == flush_at);
            #1;
            if (stallOut) stalls++;
            chk({tag, "_hold_addr"}, memAddr, eaddr);
            step;
        end
        flushIn = 1'b0;
        memAck = 1'b1;
        memRdata = rd;
        #1 chk({tag, "_ack_stall"}, stallOut, 1'b0);
        step;
        memAck = 1'b0;
        memRdata = 32'h0;
        validIn = 1'b0;
        chk({tag, "_req_drop"}, memReq, 1'b0);
        chk({tag, "_stall_cycles"}, stalls, nwait + 1);
    endtask

    always @(negedge clk) begin
        if (resetIn_n) begin
            if (wbValidOut) begin
                if (q.size() == 0) chk("wb_unexpected", wbValidOut, 1'b0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_addr", {27'h0, writeBackAddrOut}, {27'h0, e.wa});
                    chk("wb_we", writeEnableOut, e.we);
                    chk("wb_mis", misalignOut, e.mis);
                    if (e.cd) chk("wb_data", dataOut, e.data);
                end
            end else if (misalignOut) chk("mis_stray", misalignOut, 1'b0);
        end
    end

    initial begin
        resetIn_n = 1'b0;
        drive(1'b0, MEMOP_NONE, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        memAck = 1'b0;
        memRdata = 32'h0;
        #12;
        chk("rst_req", memReq, 1'b0);
        chk("rst_wbvalid", wbValidOut, 1'b0);
        chk("rst_data", dataOut, 32'h0);
        chk("rst_be", {28'h0, memBe}, 32'h0);
        chk("rst_stall", stallOut, 1'b0);
        resetIn_n = 1'b1;

        do_single("alu", MEMOP_NONE, 3'b000, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
        do_single("rsvd", 2'b11, FUNCT3_LW, 32'h0000_0777, 5'd6, 1'b1, 1'b0);
        do_mem("lb_neg", MEMOP_LOAD, FUNCT3_LB, 32'h103, 32'h0, 32'h80FF_0000, 5'd10,
               2, -1, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_mem("lb_pos", MEMOP_LOAD, FUNCT3_LB, 32'h102, 32'h0, 32'h007F_0000, 5'd11,
               1, -1, 32'h100, 4'b0100, 32'h0, 32'h0000_007F);
        do_mem("sh", MEMOP_STORE, FUNCT3_LH, 32'h22, 32'h0000_ABCD, 32'h0, 5'd12,
               1, -1, 32'h20, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_mem("lbu", MEMOP_LOAD, FUNCT3_LBU, 32'h101, 32'h0, 32'h1234_80AB, 5'd13,
               0, -1, 32'h100, 4'b0010, 32'h0, 32'h0000_0080);
        do_mem("lh", MEMOP_LOAD, FUNCT3_LH, 32'h202, 32'h0, 32'h8001_1234, 5'd14,
               1, -1, 32'h200, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_mem("lhu", MEMOP_LOAD, FUNCT3_LHU, 32'h200, 32'h0, 32'h0000_F00F, 5'd15,
               2, -1, 32'h200, 4'b0011, 32'h0, 32'h0000_F00F);
        do_mem("sb", MEMOP_STORE, FUNCT3_LB, 32'h31, 32'h1234_565A, 32'h0, 5'd16,
               0, -1, 32'h30, 4'b0010, 32'h5A5A_5A5A, 32'h0);
        do_mem("sw", MEMOP_STORE, FUNCT3_LW, 32'h40, 32'hCAFE_BABE, 32'h0, 5'd17,
               1, -1, 32'h40, 4'b1111, 32'hCAFE_BABE, 32'h0);
        do_single("lw_mis", MEMOP_LOAD, FUNCT3_LW, 32'h05, 5'd9, 1'b0, 1'b1);
        do_single("sh_mis", MEMOP_STORE, FUNCT3_LH, 32'h21, 5'd8, 1'b0, 1'b1);
        do_mem("lw_flush", MEMOP_LOAD, FUNCT3_LW, 32'h44, 32'h0, 32'h5555_AAAA, 5'd18,
               3, 1, 32'h44, 4'b1111, 32'h0, 32'h0);
        do_mem("lw_after_flush", MEMOP_LOAD, FUNCT3_LW, 32'h48, 32'h0, 32'h0102_0304, 5'd19,
               1, -1, 32'h48, 4'b1111, 32'h0, 32'h0102_0304);

        step;
        drive(1'b1, MEMOP_LOAD, FUNCT3_LW, 32'h80, 32'h0, 1'b1, 5'd3, 1'b1);
        #1 chk("idle_flush_stall", stallOut, 1'b0);
        step;
        validIn = 1'b0;
        flushIn = 1'b0;
        chk("idle_flush_noreq", memReq, 1'b0);

        step;
        memAck = 1'b1;
        step;
        memAck = 1'b0;
        chk("idle_ack_noreq", memReq, 1'b0);

        step;
        drive(1'b1, MEMOP_LOAD, FUNCT3_LW, 32'h40, 32'h0, 1'b1, 5'd4, 1'b0);
        step;
        chk("rst_wait_req", memReq, 1'b1);
        validIn = 1'b0;
        #2 resetIn_n = 1'b0;
        #1;
        chk("rst_wait_req_drop", memReq, 1'b0);
        chk("rst_wait_addr", memAddr, 32'h0);
        chk("rst_wait_be", {28'h0, memBe}, 32'h0);
        chk("rst_wait_data", dataOut, 32'h0);
        chk("rst_wait_wbvalid", wbValidOut, 1'b0);
        chk("rst_wait_idle", stallOut, 1'b0);
        step;
        resetIn_n = 1'b1;

        do_mem("lw_zero_wait", MEMOP_LOAD, FUNCT3_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd20,
               0, -1, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        step;
        step;
        chk("sb_empty", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
